lsu_mem: RTL
============

LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, max cycles waiting for bus_gnt_i or bus_rvalid_i before error.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 valid_i  input  1  MEM-stage instruction valid.
REQ-005 opcode_i  input  7  instruction opcode; LOAD=7'b0000011, STORE=7'b0100011.
REQ-006 funct3_i  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 alu_out_i  input  32  effective byte address.
REQ-008 store_data_i  input  32  rs2 value for stores.
REQ-009 stall_o  output  1  freeze upstream pipeline and mem_wb while high.
REQ-010 load_out_o  output  32  aligned, sign/zero-extended load result for mem_wb load_out_i.
REQ-011 misalign_o  output  1  one-cycle pulse: misaligned access.
REQ-012 bus_err_o  output  1  one-cycle pulse: bus timeout.
REQ-013 bus_req_o  output  1  bus request, held until granted.
REQ-014 bus_we_o  output  1  1 = store, 0 = load.
REQ-015 bus_addr_o  output  32  word address (alu_out_i[31:2], 2'b00).
REQ-016 bus_wdata_o  output  32  store data replicated into byte lanes.
REQ-017 bus_wstrb_o  output  4  byte enables; 4'b0000 for loads.
REQ-018 bus_gnt_i  input  1  request accepted this cycle.
REQ-019 bus_rvalid_i  input  1  read data valid.
REQ-020 bus_rdata_i  input  32  read data word.

Function
REQ-021 FSM states IDLE, REQ, RWAIT, DONE SHALL be the only states.
REQ-022 mem_op = valid_i && (opcode LOAD or STORE); in IDLE with mem_op, aligned -> REQ; misaligned -> DONE with misalign_o pulsed, no bus request.
REQ-023 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0; B never misaligned.
REQ-024 REQ: bus_req_o=1 with addr/we/wdata/wstrb registered stable; on bus_gnt_i, store -> DONE, load -> RWAIT.
REQ-025 RWAIT: on bus_rvalid_i capture extracted byte/half/word into load_out_o, -> DONE.
REQ-026 Byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-027 Store lanes: SB wdata={4{b}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{h}}, wstrb=4'b0011<<{addr[1],1'b0}; SW wstrb=4'b1111.
REQ-028 stall_o = mem_op && state!=DONE (combinational); DONE lasts exactly one cycle, then IDLE.
REQ-029 Timeout counter counts cycles in REQ/RWAIT; at TIMEOUT_CYC -> DONE, bus_err_o pulsed, load_out_o=0, bus_req_o dropped.
REQ-030 bus_gnt_i and bus_rvalid_i in same cycle during REQ (zero-wait load) SHALL capture data and go directly to DONE.
REQ-031 bus_rvalid_i outside RWAIT/REQ-with-gnt SHALL be ignored.
REQ-032 Non-memory instructions: stall_o=0, no bus activity, load_out_o holds.
REQ-033 Minimum latency: aligned access with immediate grant/data completes in 2 cycles (REQ, DONE).

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, timeout counter 0, and all outputs 0, including mid-transaction (bus_req_o drops immediately).
REQ-035 After reset release, first action occurs on the first rising edge with mem_op.

Structure
REQ-036 Opcode and funct3 constants SHALL come from the shared define.v header; FSM state encodings local.
REQ-037 One sub-module natural: lsu_align (combinational load extract/extend and store lane/strobe generation).

Verification
REQ-038 LB addr 0x1003, rdata 0x80FF_FF7F -> load_out_o 0xFFFF_FF80, stall_o high 2 cycles with immediate gnt+rvalid.
REQ-039 SH addr 0x2002, data 0x0000_BEEF -> bus_wdata_o 0xBEEF_BEEF, bus_wstrb_o 4'b1100, bus_we_o 1.
REQ-040 LW addr 0x3001 -> misalign_o pulse, bus_req_o never high, stall_o released after 1 cycle.
REQ-041 LHU addr 0x4002, gnt delayed 3 cycles, rvalid 2 cycles later, rdata 0xA5A5_1234 -> load_out_o 0x0000_A5A5, bus_req_o held through delay.
REQ-042 Load with no gnt for 255 cycles -> bus_err_o pulse, load_out_o 0, FSM back to IDLE.
REQ-043 rst_n asserted in RWAIT -> bus_req_o, stall_o, load_out_o 0 without a clock edge; next LW works normally.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// lsu_mem_pkg: constants shared by the load/store unit.
//   OPC_*  : RV32 major opcodes that the LSU acts on
//   F3_*   : funct3 access size / sign encodings
//   is_mem_op() : true for LOAD or STORE opcodes
package lsu_mem_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/lsu_mem_align.sv
// lsu_mem_align: combinational lane logic for the LSU.
// Request side (current instruction):
//   req_funct3, req_off, req_data -> req_wdata (lane-replicated store data),
//   req_wstrb (byte enables), req_misalign (access crosses its natural size)
// Load side (registered access info + bus word):
//   ld_funct3, ld_off, ld_rdata -> ld_data (extracted, sign/zero-extended)
module lsu_mem_align
  import lsu_mem_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_data,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  output logic        req_misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    req_wdata    = req_data;
    req_wstrb    = 4'b1111;
    req_misalign = 1'b0;
    case (req_funct3)
      F3_B, F3_BU: begin
        req_wdata = {4{req_data[7:0]}};
        req_wstrb = 4'b0001 << req_off;
      end
      F3_H, F3_HU: begin
        req_wdata    = {2{req_data[15:0]}};
        req_wstrb    = 4'b0011 << {req_off[1], 1'b0};
        req_misalign = req_off[0];
      end
      default: begin
        req_misalign = (req_off != 2'b00);
      end
    endcase
  end

  assign ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
  assign ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store unit with a simple req/gnt/rvalid bus.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_i, opcode_i, funct3_i     MEM-stage instruction
//   alu_out_i, store_data_i         effective address, store data
//   stall_o                         hold the pipeline while the access runs
//   load_out_o                      aligned/extended load result
//   misalign_o, bus_err_o           one-cycle error pulses (during DONE)
//   bus_req_o .. bus_wstrb_o        bus request side
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i  bus response side
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a memory instruction
// REQ   | bus_req_o high, waiting for grant (zero-wait load may finish)
// RWAIT | load granted, waiting for read data
// DONE  | one-cycle completion, stall released, pulses visible
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic [31:0] load_out_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q, wdata_q, load_out_q;
  logic [3:0]    wstrb_q;
  logic [2:0]    funct3_q;
  logic          we_q, misalign_q, bus_err_q;

  logic          mem_op, is_store, accept, waiting;
  logic          load_cap, timeout;
  logic          req_misalign;
  logic [31:0]   req_wdata, ld_data;
  logic [3:0]    req_wstrb;

  assign mem_op   = valid_i && is_mem_op(opcode_i);
  assign is_store = (opcode_i == OPC_STORE);
  assign accept   = (state_q == IDLE) && mem_op && !req_misalign;
  assign waiting  = (state_q == REQ) || (state_q == RWAIT);

  lsu_mem_align u_align (
    .req_funct3   (funct3_i),
    .req_off      (alu_out_i[1:0]),
    .req_data     (store_data_i),
    .req_wdata    (req_wdata),
    .req_wstrb    (req_wstrb),
    .req_misalign (req_misalign),
    .ld_funct3    (funct3_q),
    .ld_off       (addr_q[1:0]),
    .ld_rdata     (bus_rdata_i),
    .ld_data      (ld_data)
  );

  // Grant/data take priority over the timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    load_cap = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) state_d = req_misalign ? DONE : REQ;
      end
      REQ: begin
        if (bus_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
          end else if (bus_rvalid_i) begin
            state_d  = DONE;
            load_cap = 1'b1;
          end else begin
            state_d = RWAIT;
          end
        end else if (cnt_q == '0) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      RWAIT: begin
        if (bus_rvalid_i) begin
          state_d  = DONE;
          load_cap = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = DONE;
          timeout = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      funct3_q   <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      load_out_q <= '0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == IDLE) && mem_op && req_misalign;
      bus_err_q  <= timeout;

      if (accept) begin
        addr_q   <= alu_out_i;
        funct3_q <= funct3_i;
        we_q     <= is_store;
        wdata_q  <= is_store ? req_wdata : 32'h0;
        wstrb_q  <= is_store ? req_wstrb : 4'b0000;
      end

      // Each wait phase (grant, then read data) gets its own full budget.
      if ((state_d != state_q) && ((state_d == REQ) || (state_d == RWAIT)))
        cnt_q <= CW'(TIMEOUT_CYC - 1);
      else if (waiting && (cnt_q != '0))
        cnt_q <= cnt_q - 1'b1;
      else if (!waiting)
        cnt_q <= '0;

      if (load_cap)     load_out_q <= ld_data;
      else if (timeout) load_out_q <= '0;
    end
  end

  // Gated by rst_n so the stall drops immediately when reset asserts.
  assign stall_o     = rst_n && mem_op && (state_q != DONE);
  assign load_out_o  = load_out_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;
  assign bus_req_o   = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_addr_o  = {addr_q[31:2], 2'b00};
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;

endmodule
